program_loader: RTL and testbench

//   Boot-time program loader in front of the CPU control block. Receives a length-prefixed

---
 rtl/program_loader_if.sv | 31 +++
 rtl/program_loader.sv | 121 ++++++++++++
 tb/tb_program_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Stream-in / instruction-memory-out bus for the boot program loader.
// The slave side is the loader itself; the master side is the byte source
// plus the instruction memory that observes the write strobe.
interface program_loader_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader: takes a 2-byte little-endian length header and
// that many payload bytes, packs them little-endian into 32-bit words and
// writes each word to instruction memory. cpu_enable goes high (sticky)
// once the whole image is stored; an oversized header latches error.
module program_loader #(
  parameter int ADDR_W    = 12,
  parameter int MEM_BYTES = 4096,
  parameter int LEN_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  program_loader_if.slave   bus,
  output logic              cpu_enable,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W-2:0] words_written
);

  localparam logic [2:0] HDR_LO = 3'd0;
  localparam logic [2:0] HDR_HI = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] ERR    = 3'd5;

  localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(MEM_BYTES);

  logic [2:0]        state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  byte_count;
  logic [LEN_W-1:0]  count_inc;
  logic [LEN_W-1:0]  hdr_len;
  logic [31:0]       asm_word;
  logic [31:0]       next_word;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] count_addr;
  logic [ADDR_W-1:0] word_addr;
  logic              transfer;

  // Ready is forced low while reset is held so no byte can slip in during reset.
  assign bus.in_ready = rst && ((state == HDR_LO) || (state == HDR_HI) || (state == DATA));
  assign busy         = (state == HDR_HI) || (state == DATA) || (state == WRITE);
  assign transfer     = bus.in_valid && bus.in_ready;
  assign count_inc    = byte_count + 1'b1;
  assign hdr_len      = LEN_W'({bus.in_data, len[7:0]});
  assign lane         = byte_count[1:0];
  assign count_addr   = ADDR_W'(byte_count);
  assign word_addr    = {count_addr[ADDR_W-1:2], 2'b00};

  // Merge the incoming byte into its lane; lane 0 starts a fresh word so no stale bytes survive.
  always_comb begin
    next_word = (lane == 2'b00) ? 32'h0 : asm_word;
    next_word[{lane, 3'b000} +: 8] = bus.in_data;
  end

  // Header decode, byte packing, word write strobe and the sticky status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= HDR_LO;
      len            <= '0;
      byte_count     <= '0;
      asm_word       <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_enable     <= 1'b0;
      error          <= 1'b0;
      words_written  <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        HDR_LO: begin
          if (transfer) begin
            len   <= LEN_W'(bus.in_data);
            state <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (transfer) begin
            len        <= hdr_len;
            byte_count <= '0;
            if (hdr_len == '0) begin
              state      <= DONE;
              cpu_enable <= 1'b1;
            end else if ({1'b0, hdr_len} > MAX_LEN) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (transfer) begin
            byte_count <= count_inc;
            asm_word   <= next_word;
            if ((lane == 2'b11) || (count_inc == len)) begin
              state          <= WRITE;
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= word_addr;
              bus.imem_wdata <= next_word;
            end
          end
        end
        WRITE: begin
          words_written <= words_written + 1'b1;
          if (byte_count == len) begin
            state      <= DONE;
            cpu_enable <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        DONE: state <= DONE;
        ERR:  state <= ERR;
        default: state <= HDR_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: feeds length-prefixed
// images and checks every memory write, status flag and timing relation
// against hand-computed values.
module tb_program_loader;

  localparam int ADDR_W    = 12;
  localparam int MEM_BYTES = 4096;
  localparam int LEN_W     = 16;

  logic              clk;
  logic              rst;
  logic              cpu_enable;
  logic              busy;
  logic              error;
  logic [ADDR_W-2:0] words_written;

  int checks;
  int errors;
  int cycle;
  int accept_cycle;
  int en_cycle;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  int                wr_cycle[$];

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES),
    .LEN_W     (LEN_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .cpu_enable    (cpu_enable),
    .busy          (busy),
    .error         (error),
    .words_written (words_written)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to relate acceptance, write and enable timing.
  always @(posedge clk) cycle <= cycle + 1;

  // Records every write strobe and the first cycle cpu_enable is seen high.
  always @(negedge clk) begin
    if (!rst) begin
      wr_addr.delete();
      wr_data.delete();
      wr_cycle.delete();
      en_cycle = -1;
    end else begin
      if (bus.imem_we) begin
        wr_addr.push_back(bus.imem_addr);
        wr_data.push_back(bus.imem_wdata);
        wr_cycle.push_back(cycle);
      end
      if (cpu_enable && en_cycle < 0) en_cycle = cycle;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits n falling edges, then a little more so the monitor has sampled.
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Offers one byte and holds it until accepted (bounded).
  task automatic apply_stimulus(input logic [7:0] b);
    int t;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check_output("ready_timeout", {31'b0, bus.in_ready}, 32'd1);
    end else begin
      @(posedge clk);
      #1;
      accept_cycle = cycle;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_in_ready"},   {31'b0, bus.in_ready},  32'd0);
    check_output({tag, "_imem_we"},    {31'b0, bus.imem_we},   32'd0);
    check_output({tag, "_imem_addr"},  32'(bus.imem_addr),     32'd0);
    check_output({tag, "_imem_wdata"}, bus.imem_wdata,         32'd0);
    check_output({tag, "_cpu_enable"}, {31'b0, cpu_enable},    32'd0);
    check_output({tag, "_busy"},       {31'b0, busy},          32'd0);
    check_output({tag, "_error"},      {31'b0, error},         32'd0);
    check_output({tag, "_words"},      32'(words_written),     32'd0);
  endtask

  // Asserts reset off the clock edge, checks the async clear, releases on a falling edge.
  task automatic apply_reset(input string tag);
    #3;
    rst = 1'b0;
    #1;
    check_reset_values(tag);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output({tag, "_ready_after"}, {31'b0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cycle        = 0;
    accept_cycle = 0;
    en_cycle     = -1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Test 1: L=8, two full words.
    apply_reset("rst1");
    apply_stimulus(8'h08);
    check_output("t1_busy_hdr", {31'b0, busy}, 32'd1);
    apply_stimulus(8'h00);
    apply_stimulus(8'h78); apply_stimulus(8'h56); apply_stimulus(8'h34); apply_stimulus(8'h12);
    apply_stimulus(8'hEF); apply_stimulus(8'hBE); apply_stimulus(8'hAD); apply_stimulus(8'hDE);
    settle(4);
    check_output("t1_nwrites", wr_data.size(), 32'd2);
    check_output("t1_addr0",   32'(wr_addr[0]), 32'd0);
    check_output("t1_data0",   wr_data[0],      32'h12345678);
    check_output("t1_addr1",   32'(wr_addr[1]), 32'd4);
    check_output("t1_data1",   wr_data[1],      32'hDEADBEEF);
    check_output("t1_latency", wr_cycle[1],     accept_cycle);
    check_output("t1_words",   32'(words_written), 32'd2);
    check_output("t1_cpu_en",  {31'b0, cpu_enable}, 32'd1);
    check_output("t1_en_time", en_cycle,        wr_cycle[1] + 1);
    check_output("t1_busy",    {31'b0, busy},   32'd0);
    check_output("t1_ready",   {31'b0, bus.in_ready}, 32'd0);
    check_output("t1_hold_addr",  32'(bus.imem_addr), 32'd4);
    check_output("t1_hold_wdata", bus.imem_wdata,     32'hDEADBEEF);

    // Test 2: L=6, partial last word padded with zeros.
    apply_reset("rst2");
    apply_stimulus(8'h06); apply_stimulus(8'h00);
    apply_stimulus(8'h01); apply_stimulus(8'h02); apply_stimulus(8'h03); apply_stimulus(8'h04);
    apply_stimulus(8'hAA); apply_stimulus(8'hBB);
    settle(4);
    check_output("t2_nwrites", wr_data.size(), 32'd2);
    check_output("t2_data0",   wr_data[0],      32'h04030201);
    check_output("t2_addr1",   32'(wr_addr[1]), 32'd4);
    check_output("t2_data1",   wr_data[1],      32'h0000BBAA);
    check_output("t2_latency", wr_cycle[1],     accept_cycle);
    check_output("t2_words",   32'(words_written), 32'd2);
    check_output("t2_cpu_en",  {31'b0, cpu_enable}, 32'd1);

    // Test 3: empty image.
    apply_reset("rst3");
    apply_stimulus(8'h00); apply_stimulus(8'h00);
    settle(1);
    check_output("t3_en_time", en_cycle,        accept_cycle);
    settle(3);
    check_output("t3_nwrites", wr_data.size(), 32'd0);
    check_output("t3_cpu_en",  {31'b0, cpu_enable}, 32'd1);
    check_output("t3_ready",   {31'b0, bus.in_ready}, 32'd0);
    check_output("t3_busy",    {31'b0, busy},   32'd0);

    // Test 4: oversized header (MEM_BYTES+4 = 0x1004), then ignored traffic.
    apply_reset("rst4");
    apply_stimulus(8'h04); apply_stimulus(8'h10);
    settle(1);
    check_output("t4_error", {31'b0, error},        32'd1);
    check_output("t4_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    settle(6);
    bus.in_valid = 1'b0;
    settle(2);
    check_output("t4_nwrites", wr_data.size(),      32'd0);
    check_output("t4_words",   32'(words_written),  32'd0);
    check_output("t4_error_sticky", {31'b0, error}, 32'd1);
    check_output("t4_cpu_en",  {31'b0, cpu_enable}, 32'd0);
    check_output("t4_busy",    {31'b0, busy},       32'd0);

    // Test 5: L=4 with an idle cycle between every byte.
    apply_reset("rst5");
    apply_stimulus(8'h04); settle(1); apply_stimulus(8'h00); settle(1);
    apply_stimulus(8'h78); settle(1); apply_stimulus(8'h56); settle(1);
    apply_stimulus(8'h34); settle(1); apply_stimulus(8'h12);
    settle(4);
    check_output("t5_nwrites", wr_data.size(),      32'd1);
    check_output("t5_addr0",   32'(wr_addr[0]),     32'd0);
    check_output("t5_data0",   wr_data[0],          32'h12345678);
    check_output("t5_words",   32'(words_written),  32'd1);
    check_output("t5_cpu_en",  {31'b0, cpu_enable}, 32'd1);

    // Test 6: reset after three payload bytes, then a fresh L=4 image.
    apply_reset("rst6a");
    apply_stimulus(8'h08); apply_stimulus(8'h00);
    apply_stimulus(8'h11); apply_stimulus(8'h22); apply_stimulus(8'h33);
    check_output("t6_busy_mid", {31'b0, busy}, 32'd1);
    apply_reset("rst6b");
    apply_stimulus(8'h04); apply_stimulus(8'h00);
    apply_stimulus(8'h78); apply_stimulus(8'h56); apply_stimulus(8'h34); apply_stimulus(8'h12);
    settle(4);
    check_output("t6_nwrites", wr_data.size(),      32'd1);
    check_output("t6_addr0",   32'(wr_addr[0]),     32'd0);
    check_output("t6_data0",   wr_data[0],          32'h12345678);
    check_output("t6_words",   32'(words_written),  32'd1);
    check_output("t6_cpu_en",  {31'b0, cpu_enable}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
